bp_mem_traffic_checker: RTL
===========================

// Module: bp_mem_traffic_checker
// PURPOSE
//  Parametrised memory traffic generator/checker for board and sim DRAM bring-up.
//  Writes a deterministic pattern over a configurable address window, reads it back
//  with up to max_outstanding_p reads in flight, and compares every response.
//  Sits in place of the core on the memory-controller request/response port; reports
//  pass/fail and error statistics to LEDs or the testbench.
// PARAMETERS
//  addr_width_p       28     byte-address width of cmd_addr_o
//  data_width_p       64     word width; multiple of 32, >= 32
//  base_addr_p        0      first byte address of the test window
//  num_words_p        1024   words tested; >= 1
//  stride_p           8      byte step between words; >= data_width_p/8
//  max_outstanding_p  4      max reads in flight; >= 1
// PORTS
//  clk_i              in   1              clock
//  reset_i            in   1              async reset, active-high
//  start_i            in   1              pulse; starts a run when IDLE or DONE
//  cmd_v_o            out  1              command valid
//  cmd_w_o            out  1              1 = write, 0 = read
//  cmd_addr_o         out  addr_width_p   byte address
//  cmd_data_o         out  data_width_p   write data (0 on reads)
//  cmd_ready_i        in   1              command accepted when cmd_v_o & cmd_ready_i
//  resp_v_i           in   1              read response valid; in request order
//  resp_data_i        in   data_width_p   read data
//  resp_yumi_o        out  1              response consumed
//  busy_o             out  1              run in progress
//  done_o             out  1              run complete (sticky until next start)
//  pass_o             out  1              done_o & error count == 0
//  error_cnt_o        out  32             mismatches, saturating at 32'hFFFF_FFFF
//  first_err_addr_o   out  addr_width_p   address of first mismatch
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters and first_err_addr cleared.
//  Reset mid-run: abandon immediately; in-flight responses after reset are ignored.
//  pattern(i) = data_width_p/32 copies of {~i[15:0], i[15:0]}; addr(i) = base + i*stride.
//  FSM: IDLE -start_i-> WRITE -last write accepted-> READ -last resp-> DONE -start_i-> WRITE.
//   start_i in WRITE/READ is ignored. Start from DONE clears done_o, counters, first_err.
//  WRITE: cmd_v_o=1, cmd_w_o=1, word i; i advances on handshake only; fields stable
//   while cmd_v_o & ~cmd_ready_i. One write/cycle max; no write responses.
//  READ: cmd_v_o=1 iff rd_issued < num_words_p and outstanding < max_outstanding_p.
//   resp_yumi_o = resp_v_i in READ (zero-bubble accept). Responses compare with
//   pattern(rd_checked); rd_checked increments per response.
//  outstanding: +1 on read handshake, -1 on resp; both in one cycle -> unchanged.
//   Full issue rate: resp in same cycle as issue at the limit lets next read issue.
//  resp_v_i in IDLE/WRITE/DONE or with outstanding==0: counted as one error, not acked.
//  Mismatch: error_cnt_o += 1 (saturating); first_err_addr_o latched on first only.
//  Enter DONE the cycle after the last response is consumed; busy_o = WRITE|READ.
//  Counters sized $clog2(num_words_p+1), $clog2(max_outstanding_p+1); no wrap.
// CONFIGURATION
//  BP_MEM_TRAFFIC_CHECKER_STOP_ON_ERROR_EN
//   defined: first mismatch -> stop issuing reads, drain outstanding responses
//    (consumed, not compared), then DONE with error_cnt_o == 1.
//   undefined: run all num_words_p reads; every mismatch counted.
// TESTING
//  1 num_words_p=16, ready=1, 1-cycle resp memory -> 16 writes, 16 reads, done, pass, errs 0.
//  2 Random cmd_ready_i stall 50%, resp latency 1..20 -> outstanding never > 4; pass_o=1.
//  3 Memory corrupts word 5 bit 0 -> error_cnt_o=1, first_err_addr_o=base+40, pass_o=0.
//  4 STOP_ON_ERROR_EN, words 3 and 9 bad -> error_cnt_o=1, no read of word >= 3+4 issued.
//  5 reset_i asserted mid-READ with 3 outstanding -> next cycle IDLE, all outputs 0;
//    restart -> clean pass.
//  6 max_outstanding_p=1, resp same cycle as issue-eligible -> back-to-back reads; start_i
//    during READ ignored; start_i in DONE reruns and clears counters.

Source files
------------

// File: rtl/bp_mem_traffic_checker.sv
// Memory traffic generator/checker: writes a deterministic pattern over an address
// window, reads it back with bounded outstanding reads and counts mismatches.
// Optional feature macro: BP_MEM_TRAFFIC_CHECKER_STOP_ON_ERROR_EN (stop reading and drain on first mismatch).
module bp_mem_traffic_checker #(
    parameter int              addr_width_p      = 28,
    parameter int              data_width_p      = 64,
    parameter longint unsigned base_addr_p       = 0,
    parameter int              num_words_p       = 1024,
    parameter int              stride_p          = 8,
    parameter int              max_outstanding_p = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    output logic                    cmd_v_o,
    output logic                    cmd_w_o,
    output logic [addr_width_p-1:0] cmd_addr_o,
    output logic [data_width_p-1:0] cmd_data_o,
    input  logic                    cmd_ready_i,
    input  logic                    resp_v_i,
    input  logic [data_width_p-1:0] resp_data_i,
    output logic                    resp_yumi_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic [31:0]             error_cnt_o,
    output logic [addr_width_p-1:0] first_err_addr_o
);

    localparam int CntW = $clog2(num_words_p + 1);
    localparam int OutW = $clog2(max_outstanding_p + 1);
    localparam int Reps = data_width_p / 32;
    localparam logic [CntW-1:0] NumWords = CntW'(num_words_p);
    localparam logic [CntW-1:0] LastIdx  = CntW'(num_words_p - 1);
    localparam logic [OutW-1:0] MaxOut   = OutW'(max_outstanding_p);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_READ  = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                  r_state;
    state_e                  w_state_next;
    logic [CntW-1:0]         r_wr_idx;
    logic [CntW-1:0]         r_rd_issued;
    logic [CntW-1:0]         r_rd_checked;
    logic [OutW-1:0]         r_outstanding;
    logic [31:0]             r_err_cnt;
    logic [addr_width_p-1:0] r_first_err_addr;
    logic                    r_first_err_valid;

    logic                    w_start;
    logic                    w_is_read;
    logic                    w_resp_ack;
    logic                    w_spurious;
    logic                    w_mismatch;
    logic                    w_stopped;
    logic                    w_stop_now;
    logic                    w_rd_eligible;
    logic                    w_rd_fire;
    logic                    w_wr_fire;
    logic [OutW-1:0]         w_out_next;
    logic                    w_last_resp;
    logic                    w_drained;

    function automatic logic [data_width_p-1:0] pattern(input logic [CntW-1:0] idx);
        logic [31:0] l_idx;
        l_idx = 32'(idx);
        return {Reps{~l_idx[15:0], l_idx[15:0]}};
    endfunction

    function automatic logic [addr_width_p-1:0] word_addr(input logic [CntW-1:0] idx);
        return addr_width_p'(base_addr_p) + addr_width_p'(idx) * addr_width_p'(stride_p);
    endfunction

`ifdef BP_MEM_TRAFFIC_CHECKER_STOP_ON_ERROR_EN
    logic r_stop;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stop <= 1'b0;
        end else if (w_start) begin
            r_stop <= 1'b0;
        end else if (w_mismatch) begin
            r_stop <= 1'b1;
        end
    end

    assign w_stopped  = r_stop;
    assign w_stop_now = r_stop | w_mismatch;
`else
    assign w_stopped  = 1'b0;
    assign w_stop_now = 1'b0;
`endif

    // A response arriving at the outstanding limit frees its slot in the same cycle,
    // so eligibility looks at the post-response count to keep reads back-to-back.
    always_comb begin
        w_start       = start_i && ((r_state == S_IDLE) || (r_state == S_DONE));
        w_is_read     = (r_state == S_READ);
        w_resp_ack    = w_is_read && resp_v_i && (r_outstanding != '0);
        w_spurious    = resp_v_i && !w_resp_ack;
        w_mismatch    = w_resp_ack && !w_stopped && (resp_data_i != pattern(r_rd_checked));
        w_rd_eligible = w_is_read && (r_rd_issued != NumWords) && !w_stop_now &&
                        ((r_outstanding < MaxOut) || w_resp_ack);
        w_rd_fire     = w_rd_eligible && cmd_ready_i;
        w_wr_fire     = (r_state == S_WRITE) && cmd_ready_i;
        w_out_next    = r_outstanding + OutW'(w_rd_fire) - OutW'(w_resp_ack);
        w_last_resp   = w_resp_ack && (r_rd_checked == LastIdx);
        w_drained     = w_stop_now && w_resp_ack && (w_out_next == '0);
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (start_i) w_state_next = S_WRITE;
            S_WRITE: if (w_wr_fire && (r_wr_idx == LastIdx)) w_state_next = S_READ;
            S_READ:  if (w_last_resp || w_drained) w_state_next = S_DONE;
            S_DONE:  if (start_i) w_state_next = S_WRITE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_v_o    = 1'b0;
        cmd_w_o    = 1'b0;
        cmd_addr_o = '0;
        cmd_data_o = '0;
        case (r_state)
            S_WRITE: begin
                cmd_v_o    = 1'b1;
                cmd_w_o    = 1'b1;
                cmd_addr_o = word_addr(r_wr_idx);
                cmd_data_o = pattern(r_wr_idx);
            end
            S_READ: begin
                cmd_v_o    = w_rd_eligible;
                cmd_addr_o = w_rd_eligible ? word_addr(r_rd_issued) : '0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Progress counters and error statistics; a start from IDLE or DONE clears them all.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_idx          <= '0;
            r_rd_issued       <= '0;
            r_rd_checked      <= '0;
            r_outstanding     <= '0;
            r_err_cnt         <= '0;
            r_first_err_addr  <= '0;
            r_first_err_valid <= 1'b0;
        end else if (w_start) begin
            r_wr_idx          <= '0;
            r_rd_issued       <= '0;
            r_rd_checked      <= '0;
            r_outstanding     <= '0;
            r_err_cnt         <= '0;
            r_first_err_addr  <= '0;
            r_first_err_valid <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                r_wr_idx <= r_wr_idx + CntW'(1);
            end
            if (w_rd_fire) begin
                r_rd_issued <= r_rd_issued + CntW'(1);
            end
            if (w_resp_ack) begin
                r_rd_checked <= r_rd_checked + CntW'(1);
            end
            r_outstanding <= w_out_next;
            if ((w_mismatch || w_spurious) && (r_err_cnt != 32'hFFFF_FFFF)) begin
                r_err_cnt <= r_err_cnt + 32'd1;
            end
            if (w_mismatch && !r_first_err_valid) begin
                r_first_err_addr  <= word_addr(r_rd_checked);
                r_first_err_valid <= 1'b1;
            end
        end
    end

    assign resp_yumi_o      = w_resp_ack;
    assign busy_o           = (r_state == S_WRITE) || (r_state == S_READ);
    assign done_o           = (r_state == S_DONE);
    assign pass_o           = done_o && (r_err_cnt == '0);
    assign error_cnt_o      = r_err_cnt;
    assign first_err_addr_o = r_first_err_addr;

endmodule
